// File: rtl/i2c_pkg.sv
// Shared I2C types and constants for the master and the address-matching slave.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      WDATA,
      WACK,
      RDATA,
      MNACK,
      STOP,
      DONE
   } mst_state_e;

   localparam logic I2C_ACK         = 1'b0;
   localparam logic I2C_NACK        = 1'b1;
   localparam int   BITS_PER_BYTE   = 8;
   localparam int   START_QUARTERS  = 3;
   localparam int   STOP_QUARTERS   = 5;

   // Quarter length actually used: never shorter than the floor.
   function automatic logic [15:0] clamp_div(input logic [15:0] div, input logic [15:0] min_div);
      return (div < min_div) ? min_div : div;
   endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Host command/response bundle of the I2C master.
// Ports: start/addr/rw/data_in_master (host -> master), data_out_master/ready/done_tick/ack_error (master -> host).
// Backpressure: start is only taken while ready=1; the host holds the command until then.
interface i2c_master_if;
   logic       start;
   logic [6:0] addr;
   logic       rw;
   logic [7:0] data_in_master;
   logic [7:0] data_out_master;
   logic       ready;
   logic       done_tick;
   logic       ack_error;

   // View of the I2C master block itself.
   modport master (
      input  start, addr, rw, data_in_master,
      output data_out_master, ready, done_tick, ack_error
   );

   // View of the host driving commands into the master.
   modport slave (
      output start, addr, rw, data_in_master,
      input  data_out_master, ready, done_tick, ack_error
   );
endinterface

// File: rtl/i2c_quarter_timer.sv
// Quarter-bit timebase: counts 0..d-1, pulses quarter_tick on d-1 and steps a 2-bit quarter index.
// Ports: clk, reset (sync, active-high), enable, load (restart at quarter 0), d, quarter_tick, quarter_idx.
// Latency: tick combinational from the count; load takes effect on the next clk edge; no backpressure.
module i2c_quarter_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] d,
   output logic        quarter_tick,
   output logic [1:0]  quarter_idx
);

   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;

   // Not gated by load: the owner raises load in response to the tick.
   assign quarter_tick = enable && (cnt_q == d - 16'd1);
   assign quarter_idx  = idx_q;

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (load) begin
         cnt_d = 16'd0;
         idx_d = 2'd0;
      end else if (enable) begin
         if (quarter_tick) begin
            cnt_d = 16'd0;
            idx_d = idx_q + 2'd1;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 16'd0;
         idx_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, addr+rw, ACK, one data byte, ACK/NACK, STOP.
// Ports: clk, reset (sync, active-high), divisor, host (i2c_master_if.master), scl (push-pull), sda (open-drain).
// Latency: 80*D cycles accept+1 -> done_tick (44*D on address NACK); start ignored while ready=0.
module i2c_master
   import i2c_pkg::*;
#(
   parameter int MIN_DIVISOR = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] divisor,
   i2c_master_if.master host,
   output logic        scl,
   inout  wire         sda
);

   mst_state_e  state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [6:0]  addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [7:0]  wdat_q, wdat_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  dout_q, dout_d;
   logic [3:0]  bit_q, bit_d;
   logic        ack_err_q, ack_err_d;
   logic        sample_q, sample_d;

   logic        accept;
   logic        tick;
   logic [1:0]  qidx;
   logic        slot_end;
   logic        samp;
   logic        sda_oe;
   logic        sda_in;
   logic        timer_en;
   logic        timer_load;
   logic [7:0]  addr_byte;

   assign accept     = host.start && (state_q == IDLE);
   assign slot_end   = tick && (qidx == 2'd3);
   assign samp       = tick && (qidx == 2'd2);   // last cycle of Q3
   assign timer_en   = (state_q != IDLE) && (state_q != DONE);
   // Every phase begins at quarter 0 with a fresh count.
   assign timer_load = (state_d != state_q);
   assign addr_byte  = {addr_q, rw_q};

   assign sda    = sda_oe ? 1'b0 : 1'bz;
   assign sda_in = sda;

   i2c_quarter_timer u_qtimer (
      .clk          (clk),
      .reset        (reset),
      .enable       (timer_en),
      .load         (timer_load),
      .d            (div_q),
      .quarter_tick (tick),
      .quarter_idx  (qidx)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = START;
         START:    if (tick && bit_q == 4'(START_QUARTERS - 1)) state_d = ADDR;
         ADDR:     if (slot_end && bit_q == 4'(BITS_PER_BYTE - 1)) state_d = ADDR_ACK;
         ADDR_ACK: if (slot_end) begin
                      if (sample_q == I2C_NACK) state_d = STOP;
                      else if (rw_q)            state_d = RDATA;
                      else                      state_d = WDATA;
                   end
         WDATA:    if (slot_end && bit_q == 4'(BITS_PER_BYTE - 1)) state_d = WACK;
         WACK:     if (slot_end) state_d = STOP;
         RDATA:    if (slot_end && bit_q == 4'(BITS_PER_BYTE - 1)) state_d = MNACK;
         MNACK:    if (slot_end) state_d = STOP;
         STOP:     if (tick && bit_q == 4'(STOP_QUARTERS - 1)) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // In bit slots scl is low for quarters 0-1 and high for 2-3, i.e. qidx[1].
   // Bit index b maps to byte position 7-b, which for 3 bits is ~b.
   always_comb begin
      scl    = 1'b1;
      sda_oe = 1'b0;
      case (state_q)
         START: begin
            scl    = (bit_q != 4'd2);
            sda_oe = 1'b1;
         end
         ADDR: begin
            scl    = qidx[1];
            sda_oe = ~addr_byte[~bit_q[2:0]];
         end
         WDATA: begin
            scl    = qidx[1];
            sda_oe = ~wdat_q[~bit_q[2:0]];
         end
         ADDR_ACK, WACK, RDATA, MNACK: begin
            scl    = qidx[1];
            sda_oe = 1'b0;
         end
         STOP: begin
            scl    = (bit_q != 4'd0);
            sda_oe = (bit_q < 4'd3);   // release with scl high -> STOP condition
         end
         default: begin
            scl    = 1'b1;
            sda_oe = 1'b0;
         end
      endcase
   end

   assign host.ready           = (state_q == IDLE) || (state_q == DONE);
   assign host.done_tick       = (state_q == DONE);
   assign host.ack_error       = ack_err_q;
   assign host.data_out_master = dout_q;

   // ---------------- datapath ----------------
   always_comb begin
      div_d     = div_q;
      addr_d    = addr_q;
      rw_d      = rw_q;
      wdat_d    = wdat_q;
      rx_d      = rx_q;
      dout_d    = dout_q;
      bit_d     = bit_q;
      ack_err_d = ack_err_q;
      sample_d  = sample_q;

      if (accept) begin
         div_d     = clamp_div(divisor, 16'(MIN_DIVISOR));
         addr_d    = host.addr;
         rw_d      = host.rw;
         wdat_d    = host.data_in_master;
         ack_err_d = 1'b0;
      end

      // bit_q counts quarters in START/STOP and whole slots elsewhere.
      if (state_d != state_q)
         bit_d = 4'd0;
      else if (state_q == START || state_q == STOP) begin
         if (tick) bit_d = bit_q + 4'd1;
      end else if (slot_end)
         bit_d = bit_q + 4'd1;

      if (samp) begin
         sample_d = sda_in;
         if (state_q == RDATA) rx_d = {rx_q[6:0], sda_in};
      end

      if (slot_end && (state_q == ADDR_ACK || state_q == WACK) && sample_q == I2C_NACK)
         ack_err_d = 1'b1;

      if (slot_end && state_q == MNACK)
         dout_d = rx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q     <= 16'd0;
         addr_q    <= 7'd0;
         rw_q      <= 1'b0;
         wdat_q    <= 8'd0;
         rx_q      <= 8'd0;
         dout_q    <= 8'd0;
         bit_q     <= 4'd0;
         ack_err_q <= 1'b0;
         sample_q  <= 1'b0;
      end else begin
         div_q     <= div_d;
         addr_q    <= addr_d;
         rw_q      <= rw_d;
         wdat_q    <= wdat_d;
         rx_q      <= rx_d;
         dout_q    <= dout_d;
         bit_q     <= bit_d;
         ack_err_q <= ack_err_d;
         sample_q  <= sample_d;
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural bus slave at address 0x51.
// Slave ACKs its address and written bytes, returns 0x3C on reads, ignores other addresses.
// Latency and bus content are checked against hand-computed values.
module tb_i2c_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] divisor = 16'd4;
   logic        scl;
   wire         sda;
   logic        slv_oe = 1'b0;

   i2c_master_if hif ();

   i2c_master #(.MIN_DIVISOR(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .divisor (divisor),
      .host    (hif),
      .scl     (scl),
      .sda     (sda)
   );

   pullup (sda);
   assign sda = slv_oe ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   // ---------------- behavioural slave ----------------
   typedef enum {S_IDLE, S_ADDR, S_AACK, S_WDAT, S_WACK, S_RDAT, S_MACK} sph_e;
   sph_e       ph = S_IDLE;
   logic       scl_p = 1'b1;
   logic       sda_p = 1'b1;
   int         bitn = 0;
   logic [7:0] sh = 8'd0;
   logic [7:0] rd_byte = 8'h3C;
   logic [6:0] my_addr = 7'h51;
   logic [7:0] got_addr = 8'd0;
   logic [7:0] got_w = 8'd0;
   int         w_cnt = 0;
   int         scl_rises = 0;
   logic       mnack_seen = 1'b0;

   always @(negedge clk) begin
      if (scl && scl_p && sda_p && !sda) begin
         ph = S_ADDR; bitn = 0; slv_oe = 1'b0;
      end else if (scl && scl_p && !sda_p && sda) begin
         ph = S_IDLE; slv_oe = 1'b0;
      end else if (scl && !scl_p) begin
         scl_rises++;
         case (ph)
            S_ADDR, S_WDAT: begin sh = {sh[6:0], sda}; bitn++; end
            S_MACK: mnack_seen = sda;
            default: ;
         endcase
      end else if (!scl && scl_p) begin
         case (ph)
            S_ADDR: if (bitn == 8) begin
               got_addr = sh;
               if (sh[7:1] == my_addr) begin slv_oe = 1'b1; ph = S_AACK; end
               else ph = S_IDLE;
            end
            S_AACK: begin
               slv_oe = 1'b0; bitn = 0;
               if (got_addr[0]) begin ph = S_RDAT; slv_oe = ~rd_byte[7]; end
               else ph = S_WDAT;
            end
            S_WDAT: if (bitn == 8) begin
               got_w = sh; w_cnt++; slv_oe = 1'b1; ph = S_WACK;
            end
            S_WACK: begin slv_oe = 1'b0; ph = S_IDLE; end
            S_RDAT: begin
               bitn++;
               if (bitn < 8) slv_oe = ~rd_byte[7 - bitn];
               else begin slv_oe = 1'b0; ph = S_MACK; end
            end
            S_MACK: ph = S_IDLE;
            default: ;
         endcase
      end
      scl_p = scl;
      sda_p = sda;
   end

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Issue one command, return cycles from accept+1 to done_tick (-1 on timeout).
   // chg_at: cycle at which divisor is changed to 10; busy_at: cycle of a stray start pulse.
   task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                          input logic [15:0] div, input int chg_at, input int busy_at,
                          output int lat);
      repeat (2) @(negedge clk);
      divisor = div;
      hif.start = 1'b1; hif.addr = a; hif.rw = r; hif.data_in_master = d;
      @(posedge clk); #1;
      hif.start = 1'b0;
      chk("ready_fall", hif.ready, 0);
      lat = -1;
      for (int n = 1; n <= 20000; n++) begin
         @(posedge clk); #1;
         if (n == chg_at) divisor = 16'd10;
         if (n == busy_at) begin
            hif.start = 1'b1; hif.addr = 7'h22; hif.data_in_master = 8'hFF;
         end
         if (n == busy_at + 1) hif.start = 1'b0;
         if (hif.done_tick) begin lat = n; break; end
      end
   endtask

   int lat;
   int r0, w0, dn;

   initial begin
      hif.start = 1'b0; hif.addr = 7'd0; hif.rw = 1'b0; hif.data_in_master = 8'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_ready", hif.ready, 1);
      chk("rst_done", hif.done_tick, 0);
      chk("rst_ackerr", hif.ack_error, 0);
      chk("rst_dout", hif.data_out_master, 8'h00);
      chk("rst_scl", scl, 1);
      chk("rst_sda", sda, 1);

      // Write with ACK, D=4.
      r0 = scl_rises; w0 = w_cnt;
      run_txn(7'h51, 1'b0, 8'hA5, 16'd4, 0, 0, lat);
      chk("wr_lat", lat, 320);
      chk("wr_ackerr", hif.ack_error, 0);
      chk("wr_ready", hif.ready, 1);
      chk("wr_addr", got_addr, 8'hA2);
      chk("wr_data", got_w, 8'hA5);
      chk("wr_wcnt", w_cnt - w0, 1);
      chk("wr_rises", scl_rises - r0, 19);
      chk("wr_dout_hold", hif.data_out_master, 8'h00);
      @(posedge clk); #1;
      chk("done_one_cycle", hif.done_tick, 0);
      chk("idle_ready", hif.ready, 1);

      // Read, slave returns 0x3C.
      r0 = scl_rises;
      run_txn(7'h51, 1'b1, 8'h00, 16'd4, 0, 0, lat);
      chk("rd_lat", lat, 320);
      chk("rd_ackerr", hif.ack_error, 0);
      chk("rd_dout", hif.data_out_master, 8'h3C);
      chk("rd_addr", got_addr, 8'hA3);
      chk("rd_mnack", mnack_seen, 1);
      chk("rd_rises", scl_rises - r0, 19);

      // Address NACK: nobody at 0x22.
      r0 = scl_rises; w0 = w_cnt;
      run_txn(7'h22, 1'b0, 8'h55, 16'd4, 0, 0, lat);
      chk("nack_lat", lat, 176);
      chk("nack_ackerr", hif.ack_error, 1);
      chk("nack_rises", scl_rises - r0, 10);
      chk("nack_wcnt", w_cnt - w0, 0);
      chk("nack_dout_hold", hif.data_out_master, 8'h3C);

      // Divisor 0 clamps to 2; a change to 10 mid-transaction is ignored.
      run_txn(7'h51, 1'b0, 8'hC3, 16'd0, 40, 0, lat);
      chk("clamp_lat", lat, 160);
      chk("clamp_data", got_w, 8'hC3);
      chk("clamp_ackerr", hif.ack_error, 0);

      // New divisor is latched at the next accept.
      run_txn(7'h51, 1'b0, 8'h3E, 16'd3, 0, 0, lat);
      chk("div3_lat", lat, 240);
      chk("div3_data", got_w, 8'h3E);

      // Reset for one cycle during address bit 3 (cycles 61..76 with D=4).
      repeat (2) @(negedge clk);
      divisor = 16'd4;
      hif.start = 1'b1; hif.addr = 7'h51; hif.rw = 1'b0; hif.data_in_master = 8'h11;
      @(posedge clk); #1;
      hif.start = 1'b0;
      repeat (62) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mrst_scl", scl, 1);
      chk("mrst_sda", sda, 1);
      chk("mrst_ready", hif.ready, 1);
      chk("mrst_done", hif.done_tick, 0);
      dn = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (hif.done_tick) dn++;
      end
      chk("mrst_no_done", dn, 0);
      run_txn(7'h51, 1'b0, 8'h5A, 16'd4, 0, 0, lat);
      chk("mrst_new_lat", lat, 320);
      chk("mrst_new_data", got_w, 8'h5A);
      chk("mrst_new_addr", got_addr, 8'hA2);

      // Stray start during WDATA is ignored.
      w0 = w_cnt;
      run_txn(7'h51, 1'b0, 8'h96, 16'd4, 0, 170, lat);
      chk("busy_lat", lat, 320);
      chk("busy_addr", got_addr, 8'hA2);
      chk("busy_data", got_w, 8'h96);
      chk("busy_wcnt", w_cnt - w0, 1);
      chk("busy_ackerr", hif.ack_error, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("busy_idle_ready", hif.ready, 1);
      chk("busy_idle_scl", scl, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
